ram_request_adapter: RTL and testbench

- Sits between the RV32 core's load/store unit and the RAM controller.
- Accepts one byte, halfword or word access at a time from the core, using RV32 funct3 encoding.
- Checks alignment, builds the word address, byte mask and lane-shifted write data, then runs the trigger/ready handshake on the RAM controller side.
- Returns the sign- or zero-extended load result and a response code to the core.

---
 rtl/ram_request_adapter.sv | 224 ++++++++++++++++++++++
 tb/tb_ram_request_adapter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_request_adapter.sv
// Bridges RV32 load/store requests onto the RAM controller trigger/ready handshake.
// One access in flight: decode and align, issue, wait busy, wait done, respond.
module ram_request_adapter #(
  parameter int ADDRESS_SIZE   = 28,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic                    cpu_we,
  input  logic [2:0]              cpu_funct3,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_resp_valid,
  output logic [31:0]             cpu_rdata,
  output logic [1:0]              cpu_resp_code,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [MASK_SIZE-1:0]    ram_mask,
  output logic                    ram_write_trigger,
  output logic [DATA_SIZE-1:0]    ram_write_value,
  output logic                    ram_read_trigger,
  input  logic [DATA_SIZE-1:0]    ram_read_value,
  input  logic                    ram_controller_ready,
  input  logic [3:0]              ram_error
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_OK         = 2'd0;
  localparam logic [1:0] CODE_MISALIGNED = 2'd1;
  localparam logic [1:0] CODE_RAM_ERROR  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT    = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    we_reg, we_next;
  logic [2:0]              funct3_reg, funct3_next;
  logic [1:0]              lane_reg, lane_next;
  logic [ADDRESS_SIZE-1:0] address_reg, address_next;
  logic [MASK_SIZE-1:0]    mask_reg, mask_next;
  logic [DATA_SIZE-1:0]    wvalue_reg, wvalue_next;
  logic [31:0]             rdata_reg, rdata_next;
  logic [1:0]              code_reg, code_next;
  logic [CNT_W-1:0]        count_reg, count_next;

  logic                    unused_addr;
  logic [1:0]              req_lane;
  logic                    req_bad;
  logic                    req_illegal;
  logic                    req_misaligned;
  logic [MASK_SIZE-1:0]    req_mask;
  logic [DATA_SIZE-1:0]    req_shifted;
  logic [DATA_SIZE-1:0]    req_wvalue;
  logic [DATA_SIZE-1:0]    lane_word;
  logic [31:0]             load_value;
  logic                    accept;

  assign unused_addr = ^cpu_addr;
  assign req_lane    = cpu_addr[1:0];

  // Request decode: byte enables plus the two reasons a request never reaches RAM.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_mask       = '0;
    case (cpu_funct3)
      3'b000: req_mask = MASK_SIZE'(1) << req_lane;
      3'b001: begin
        req_mask       = MASK_SIZE'(3) << req_lane;
        req_misaligned = req_lane[0];
      end
      3'b010: begin
        req_mask       = {MASK_SIZE{1'b1}};
        req_misaligned = (req_lane != 2'b00);
      end
      3'b100: begin
        req_mask    = MASK_SIZE'(1) << req_lane;
        req_illegal = cpu_we;
      end
      3'b101: begin
        req_mask       = MASK_SIZE'(3) << req_lane;
        req_misaligned = req_lane[0];
        req_illegal    = cpu_we;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  assign req_bad     = req_illegal | req_misaligned;
  assign req_shifted = cpu_wdata << {req_lane, 3'b000};

  generate
    for (genvar gi = 0; gi < MASK_SIZE; gi++) begin : g_lane
      assign req_wvalue[8*gi +: 8] = req_shifted[8*gi +: 8] & {8{req_mask[gi]}};
    end
  endgenerate

  // Bring the addressed lane down to bit 0, then extend by access type.
  assign lane_word = ram_read_value >> {lane_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_value = {{(DATA_SIZE-8){lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_value = {{(DATA_SIZE-16){lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_value = {{(DATA_SIZE-8){1'b0}}, lane_word[7:0]};
      3'b101:  load_value = {{(DATA_SIZE-16){1'b0}}, lane_word[15:0]};
      default: load_value = lane_word;
    endcase
  end

  assign cpu_req_ready = (state_reg == IDLE) && ram_controller_ready && (ram_error == 4'd0);
  assign accept        = cpu_req_valid && cpu_req_ready;

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    funct3_next  = funct3_reg;
    lane_next    = lane_reg;
    address_next = address_reg;
    mask_next    = mask_reg;
    wvalue_next  = wvalue_reg;
    rdata_next   = rdata_reg;
    code_next    = code_reg;
    count_next   = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          we_next      = cpu_we;
          funct3_next  = cpu_funct3;
          lane_next    = req_lane;
          address_next = cpu_addr[ADDRESS_SIZE+1:2];
          rdata_next   = '0;
          if (req_bad) begin
            mask_next   = '0;
            wvalue_next = '0;
            code_next   = CODE_MISALIGNED;
            state_next  = RESP;
          end else begin
            mask_next   = req_mask;
            wvalue_next = req_wvalue;
            code_next   = CODE_OK;
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        count_next = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!ram_controller_ready) begin
          count_next = '0;
          state_next = WAIT_DONE;
        end else if (count_reg == CNT_LAST) begin
          code_next  = CODE_TIMEOUT;
          state_next = RESP;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        // Completion wins over a timeout landing on the same cycle.
        if (ram_controller_ready) begin
          state_next = RESP;
          if (ram_error != 4'd0) begin
            code_next  = CODE_RAM_ERROR;
            rdata_next = '0;
          end else begin
            code_next  = CODE_OK;
            rdata_next = we_reg ? 32'd0 : load_value;
          end
        end else if (count_reg == CNT_LAST) begin
          code_next  = CODE_TIMEOUT;
          state_next = RESP;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      funct3_reg  <= 3'd0;
      lane_reg    <= 2'd0;
      address_reg <= '0;
      mask_reg    <= '0;
      wvalue_reg  <= '0;
      rdata_reg   <= '0;
      code_reg    <= CODE_OK;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      funct3_reg  <= funct3_next;
      lane_reg    <= lane_next;
      address_reg <= address_next;
      mask_reg    <= mask_next;
      wvalue_reg  <= wvalue_next;
      rdata_reg   <= rdata_next;
      code_reg    <= code_next;
      count_reg   <= count_next;
    end
  end

  assign ram_address       = address_reg;
  assign ram_mask          = mask_reg;
  assign ram_write_value   = wvalue_reg;
  assign ram_write_trigger = (state_reg == ISSUE) && we_reg;
  assign ram_read_trigger  = (state_reg == ISSUE) && !we_reg;
  assign cpu_resp_valid    = (state_reg == RESP);
  assign cpu_rdata         = rdata_reg;
  assign cpu_resp_code     = code_reg;

endmodule

// File: tb/tb_ram_request_adapter.sv
// Directed plus randomized bench for ram_request_adapter; the RAM controller
// is played cycle by cycle from the stimulus tasks.
module tb_ram_request_adapter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_resp_code;
  logic [27:0] ram_address;
  logic [3:0]  ram_mask;
  logic        ram_write_trigger;
  logic [31:0] ram_write_value;
  logic        ram_read_trigger;
  logic [31:0] ram_read_value;
  logic        ram_controller_ready;
  logic [3:0]  ram_error;

  int tests_run    = 0;
  int tests_failed = 0;

  ram_request_adapter #(
    .ADDRESS_SIZE(28), .DATA_SIZE(32), .MASK_SIZE(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_resp_code(cpu_resp_code),
    .ram_address(ram_address), .ram_mask(ram_mask),
    .ram_write_trigger(ram_write_trigger), .ram_write_value(ram_write_value),
    .ram_read_trigger(ram_read_trigger), .ram_read_value(ram_read_value),
    .ram_controller_ready(ram_controller_ready), .ram_error(ram_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, lanes byte by byte.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rval,
                                output logic bad, output logic [3:0] mask,
                                output logic [31:0] wval, output logic [31:0] rdata);
    int size;
    int off;
    logic sgn;
    logic [63:0] v;
    off = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    sgn  = (f3 < 3'd4);
    bad  = (size == 0) || (we && f3 >= 3'd4) || ((size != 0) && (off % size != 0));
    mask = 4'd0;
    wval = 32'd0;
    rdata = 32'd0;
    if (!bad) begin
      for (int i = 0; i < size; i++) begin
        mask[off+i] = 1'b1;
        wval[8*(off+i) +: 8] = wdata[8*i +: 8];
      end
      v = ({32'd0, rval} >> (8*off)) & ((64'd1 << (8*size)) - 64'd1);
      if (sgn && size < 4 && v[8*size-1]) v = v - (64'd1 << (8*size));
      rdata = v[31:0];
    end
  endfunction

  // Starts at a falling edge with the DUT idle; ends at a falling edge, idle again.
  // busy: 0 = ready never drops, else cycles ready stays low after the trigger.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rval,
                            input int busy, input logic [3:0] err);
    logic        bad;
    logic [3:0]  emask;
    logic [31:0] ewval, eload, erdata;
    logic [1:0]  ecode;
    int          resp_cyc;
    model(we, f3, addr, wdata, rval, bad, emask, ewval, eload);
    cpu_req_valid = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wdata;
    ram_controller_ready = 1'b1; ram_error = 4'd0; ram_read_value = $urandom;
    #1 check("req_ready_idle", 32'(cpu_req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    cpu_req_valid = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
    cpu_funct3 = 3'($urandom_range(0, 7));
    if (bad) begin
      check("bad_resp_valid", 32'(cpu_resp_valid), 32'd1);
      check("bad_code", 32'(cpu_resp_code), 32'd1);
      check("bad_rdata", cpu_rdata, 32'd0);
      check("bad_triggers", {30'd0, ram_write_trigger, ram_read_trigger}, 32'd0);
      @(posedge clk); @(negedge clk);
      check("bad_resp_done", 32'(cpu_resp_valid), 32'd0);
      $display("[TB] we=%0d f3=%0d addr=%h -> rejected code=%0d", we, f3, addr, cpu_resp_code);
      return;
    end
    check("issue_wtrig", 32'(ram_write_trigger), 32'(we));
    check("issue_rtrig", 32'(ram_read_trigger), 32'(!we));
    check("issue_addr", 32'(ram_address), 32'(addr[29:2]));
    check("issue_mask", 32'(ram_mask), 32'(emask));
    if (we) check("issue_wvalue", ram_write_value, ewval);
    check("issue_resp", 32'(cpu_resp_valid), 32'd0);
    if (busy == 0) begin
      resp_cyc = 2 + T; ecode = 2'd3;
    end else if (busy > T) begin
      resp_cyc = 3 + T; ecode = 2'd3;
    end else begin
      resp_cyc = 3 + busy; ecode = (err != 4'd0) ? 2'd2 : 2'd0;
    end
    erdata = (ecode == 2'd0 && !we) ? eload : 32'd0;
    for (int cyc = 1; cyc < resp_cyc; cyc++) begin
      ram_controller_ready = !(busy > 0 && cyc >= 2 && cyc <= busy + 1);
      ram_read_value       = (cyc == busy + 2) ? rval : $urandom;
      ram_error            = (cyc == busy + 2) ? err : 4'd0;
      @(posedge clk); @(negedge clk);
      if (cyc + 1 < resp_cyc) begin
        check("wait_resp", 32'(cpu_resp_valid), 32'd0);
        check("wait_triggers", {30'd0, ram_write_trigger, ram_read_trigger}, 32'd0);
        check("wait_req_ready", 32'(cpu_req_ready), 32'd0);
        check("wait_addr_hold", 32'(ram_address), 32'(addr[29:2]));
      end
    end
    ram_controller_ready = 1'b1; ram_error = 4'd0; ram_read_value = $urandom;
    check("resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("resp_code", 32'(cpu_resp_code), 32'(ecode));
    check("resp_rdata", cpu_rdata, erdata);
    check("resp_triggers", {30'd0, ram_write_trigger, ram_read_trigger}, 32'd0);
    $display("[TB] we=%0d f3=%0d addr=%h busy=%0d err=%0d -> code=%0d rdata=%h",
             we, f3, addr, busy, err, cpu_resp_code, cpu_rdata);
    @(posedge clk); @(negedge clk);
    check("resp_done", 32'(cpu_resp_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; ram_read_value = 32'd0;
    ram_controller_ready = 1'b0; ram_error = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {cpu_req_ready, cpu_resp_valid, ram_write_trigger, ram_read_trigger,
                          cpu_resp_code, ram_mask, 22'd0}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_wvalue", ram_write_value, 32'd0);
    rst_n = 1'b1;

    run_access(1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 32'd0, 3, 4'd0);
    check("sw_mask", 32'(ram_mask), 32'hF);
    check("sw_addr", 32'(ram_address), 32'd4);
    check("sw_value", ram_write_value, 32'hDEADBEEF);
    run_access(1'b0, 3'b000, 32'h13, 32'd0, 32'h80112233, 2, 4'd0);
    check("lb_mask", 32'(ram_mask), 32'h8);
    check("lb_rdata", cpu_rdata, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h13, 32'd0, 32'h80112233, 1, 4'd0);
    check("lbu_rdata", cpu_rdata, 32'h00000080);
    run_access(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'd0, 1, 4'd0);
    check("sh_mask", 32'(ram_mask), 32'hC);
    check("sh_value", ram_write_value, 32'hABCD0000);
    run_access(1'b0, 3'b001, 32'h22, 32'd0, 32'h80010000, 4, 4'd0);
    check("lh_rdata", cpu_rdata, 32'hFFFF8001);
    run_access(1'b0, 3'b010, 32'h06, 32'd0, 32'd0, 1, 4'd0);
    check("lw_mis_code", 32'(cpu_resp_code), 32'd1);
    run_access(1'b1, 3'b001, 32'h05, 32'h1234, 32'd0, 1, 4'd0);
    run_access(1'b1, 3'b100, 32'h08, 32'h1234, 32'd0, 1, 4'd0);
    run_access(1'b0, 3'b011, 32'h08, 32'd0, 32'd0, 1, 4'd0);
    run_access(1'b0, 3'b010, 32'h100, 32'd0, 32'h11223344, 0, 4'd0);
    check("timeout_busy_code", 32'(cpu_resp_code), 32'd3);
    run_access(1'b0, 3'b010, 32'h104, 32'd0, 32'h11223344, T + 5, 4'd0);
    run_access(1'b0, 3'b010, 32'h108, 32'd0, 32'h55667788, T, 4'd0);
    run_access(1'b0, 3'b010, 32'h10C, 32'd0, 32'h55667788, 2, 4'd1);
    check("err_code", 32'(cpu_resp_code), 32'd2);

    // Persisting controller error, then controller not ready: requests are ignored.
    ram_error = 4'd1; cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h200;
    #1 check("err_req_ready", 32'(cpu_req_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("err_no_trigger", {30'd0, ram_write_trigger, ram_read_trigger}, 32'd0);
      check("err_no_resp", 32'(cpu_resp_valid), 32'd0);
    end
    ram_error = 4'd0; ram_controller_ready = 1'b0;
    #1 check("busy_req_ready", 32'(cpu_req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("busy_no_trigger", {30'd0, ram_write_trigger, ram_read_trigger}, 32'd0);
    cpu_req_valid = 1'b0; ram_controller_ready = 1'b1;
    $display("[TB] requests ignored while error/busy");

    // Reset while waiting for completion.
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    cpu_req_valid = 1'b0;
    check("rstmid_rtrig", 32'(ram_read_trigger), 32'd1);
    @(posedge clk); @(negedge clk);
    ram_controller_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_outputs", {cpu_req_ready, cpu_resp_valid, ram_write_trigger, ram_read_trigger,
                             cpu_resp_code, ram_mask, 22'd0}, 32'd0);
    check("rstmid_addr", 32'(ram_address), 32'd0);
    check("rstmid_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rstmid_not_ready", 32'(cpu_req_ready), 32'd0);
    $display("[TB] reset during WAIT_DONE cleared outputs");
    run_access(1'b0, 3'b010, 32'h80, 32'd0, 32'hCAFEF00D, 1, 4'd0);
    check("post_rst_lw", cpu_rdata, 32'hCAFEF00D);

    for (int n = 0; n < 120; n++) begin
      logic [2:0] f3;
      logic       we;
      int         busy;
      int         r;
      logic [3:0] err;
      r    = $urandom_range(0, 9);
      f3   = (r < 8) ? f3_tab[r] : 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 19);
      busy = (r == 0) ? 0 : (r == 1) ? T + 3 : $urandom_range(1, 6);
      err  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      run_access(we, f3, $urandom, $urandom, $urandom, busy, err);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
